// File: rtl/cpu_trace_buffer.sv
// -----------------------------------------------------------------------------
// cpu_trace_buffer
//
// Trace capture unit for the single-cycle CPU. Per-instruction commit records
// (PC, instruction, ALU result, memory data, zero flag) are written into a
// circular buffer while armed. Capture stops on a programmable trigger (after
// an optional number of post-trigger records). The captured history is then
// streamed out oldest-first over a valid/ready port.
//
// Ports
//   clk, startin          clock (rising edge) and synchronous active-high reset
//   arm                   1-cycle pulse: start a new capture (aborts any other)
//   mode                  00 fill, 01 PC match, 10 zero flag, 11 same as 00
//   trig_pc               PC compare value for PC-match mode
//   post_count            records kept after the trigger record
//   cap_valid, *_in       commit record from the CPU
//   rd_valid, rd_ready    readout handshake
//   rd_pc .. rd_zero      readout entry (all zero while rd_valid=0)
//   rd_last               current readout entry is the final one
//   state                 0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   triggered             trigger seen in this capture
//   count                 entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module cpu_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              arm,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic [PTR_W-1:0]  post_count,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic              zero_in,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_instr,
  output logic [DATA_W-1:0] rd_alu,
  output logic [DATA_W-1:0] rd_mem,
  output logic              rd_zero,
  output logic              rd_last,
  output logic [1:0]        state,
  output logic              triggered,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic              zero;
  } entry_t;

  entry_t mem_q [DEPTH];

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wptr_q, rptr_q, remaining_q;
  logic [CNT_W-1:0]   count_q, rd_left_q;
  logic               triggered_q, rd_valid_q;
  logic [1:0]         mode_q;
  logic [DATA_W-1:0]  trig_pc_q;
  logic [PTR_W-1:0]   post_q;

  logic               wr_en, trig_hit, rd_xfer, done_entry, fill_mode;
  logic [PTR_W-1:0]   wptr_nx;
  logic [CNT_W-1:0]   count_nx;
  entry_t             rd_entry;

  // Values after the current write; the pointer wraps naturally because
  // DEPTH is a power of two.
  assign wptr_nx   = wptr_q + PTR_W'(1);
  assign count_nx  = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + CNT_W'(1);
  assign fill_mode = (mode_q == 2'b00) || (mode_q == 2'b11);
  assign rd_xfer   = rd_valid_q & rd_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    trig_hit = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_ARMED: begin
        if (cap_valid) begin
          wr_en = 1'b1;
          unique case (mode_q)
            2'b01:   trig_hit = (pc_in == trig_pc_q);
            2'b10:   trig_hit = zero_in;
            default: trig_hit = (count_q == CNT_W'(DEPTH - 1));
          endcase
          if (trig_hit) begin
            // Fill mode never keeps post-trigger records.
            state_d = (fill_mode || post_q == '0) ? S_DONE : S_POST;
          end
        end
      end
      S_POST: begin
        if (cap_valid) begin
          wr_en = 1'b1;
          if (remaining_q == PTR_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rd_xfer && rd_left_q == CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // arm overrides everything, including a record presented in the same cycle.
    if (arm) begin
      state_d  = S_ARMED;
      wr_en    = 1'b0;
      trig_hit = 1'b0;
    end
  end

  assign done_entry = (state_d == S_DONE) && (state_q != S_DONE);

  always_ff @(posedge clk) begin
    if (startin) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state updates use non-blocking assignments so every register in
  // this block sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (startin) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rd_left_q   <= '0;
      remaining_q <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      mode_q      <= 2'b00;
      trig_pc_q   <= '0;
      post_q      <= '0;
    end else if (arm) begin
      wptr_q      <= '0;
      count_q     <= '0;
      rd_left_q   <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      mode_q      <= mode;
      trig_pc_q   <= trig_pc;
      post_q      <= post_count;
    end else begin
      if (wr_en) begin
        wptr_q  <= wptr_nx;
        count_q <= count_nx;
      end
      if (trig_hit) begin
        triggered_q <= 1'b1;
        remaining_q <= post_q;
      end else if (state_q == S_POST && wr_en) begin
        remaining_q <= remaining_q - PTR_W'(1);
      end
      // Oldest entry is slot 0 until the buffer has wrapped, then the slot
      // about to be overwritten next.
      if (done_entry) begin
        rptr_q    <= (count_nx < CNT_W'(DEPTH)) ? '0 : wptr_nx;
        rd_left_q <= count_nx;
      end
      if (state_q == S_DONE) begin
        if (!rd_valid_q && rd_left_q != '0) begin
          rd_valid_q <= 1'b1;
        end else if (rd_xfer) begin
          rptr_q    <= rptr_q + PTR_W'(1);
          rd_left_q <= rd_left_q - CNT_W'(1);
          if (rd_left_q == CNT_W'(1)) rd_valid_q <= 1'b0;
        end
      end
    end
  end

  // NOTE: the trace RAM is deliberately not reset; only valid-tracking state
  // is, and outputs are masked while rd_valid is low.
  always_ff @(posedge clk) begin
    if (wr_en && !startin) begin
      mem_q[wptr_q] <= '{pc: pc_in, instr: instr_in, alu: alu_in,
                         mem: mem_in, zero: zero_in};
    end
  end

  assign rd_entry  = mem_q[rptr_q];
  assign rd_valid  = rd_valid_q;
  assign rd_pc     = rd_valid_q ? rd_entry.pc    : '0;
  assign rd_instr  = rd_valid_q ? rd_entry.instr : '0;
  assign rd_alu    = rd_valid_q ? rd_entry.alu   : '0;
  assign rd_mem    = rd_valid_q ? rd_entry.mem   : '0;
  assign rd_zero   = rd_valid_q & rd_entry.zero;
  assign rd_last   = rd_valid_q && (rd_left_q == CNT_W'(1));
  assign state     = state_q;
  assign triggered = triggered_q;
  assign count     = count_q;

endmodule
